// File: rtl/udp_panel_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : udp_panel_stream_writer
// Brief    : Parses UDP payload words into RGB pixel writes for one of
//            NUM_PANELS framebuffers; blue/green fill when idle or on button.
// Revision : 1.0 - initial release
// ============================================================================
module udp_panel_stream_writer #(
    parameter int PORT_MSB     = 16'h66,
    parameter int NUM_PANELS   = 6,
    parameter int ADDR_W       = 13,
    parameter int PANEL_PIXELS = 8192,
    parameter int TIMEOUT_LOG2 = 27,
    parameter int TOGGLE_BIT   = 26
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  button,
    input  logic                  udp_source_valid,
    input  logic                  udp_source_last,
    output logic                  udp_source_ready,
    input  logic [15:0]           udp_source_dst_port,
    input  logic [3:0]            udp_source_error,
    input  logic [31:0]           udp_source_data,
    output logic [NUM_PANELS-1:0] ctrl_en,
    output logic [3:0]            ctrl_wr,
    output logic [ADDR_W-1:0]     ctrl_addr,
    output logic [23:0]           ctrl_wdat,
    output logic                  led_reg
);

    localparam int c_PANEL_W = (NUM_PANELS > 1) ? $clog2(NUM_PANELS) : 1;
    localparam int c_CNT_W   = (ADDR_W > TOGGLE_BIT + 1) ? ADDR_W : TOGGLE_BIT + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PIXELS = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_PANEL_W-1:0]   r_panel;
    logic [ADDR_W-1:0]      r_addr;
    logic [15:0]            r_remaining;
    logic [TIMEOUT_LOG2:0]  r_timer;
    logic [c_CNT_W-1:0]     r_cnt;

    logic                   w_beat;
    logic                   w_hdr_good;
    logic                   w_accept;
    logic                   w_pattern;
    logic [ADDR_W-1:0]      w_start;
    logic [15:0]            w_count;
    logic [ADDR_W-1:0]      w_addr_next;
    logic [ADDR_W-1:0]      w_pat_addr;
    logic [NUM_PANELS-1:0]  w_onehot;

    assign ctrl_wr = 4'b0111;

    assign w_beat  = udp_source_valid && udp_source_ready;
    assign w_start = udp_source_data[ADDR_W-1:0];
    assign w_count = udp_source_data[31:16];

    assign w_hdr_good = (32'(udp_source_dst_port[15:8]) == PORT_MSB)
                     && (32'(udp_source_dst_port[7:0]) < NUM_PANELS)
                     && (udp_source_error == 4'd0)
                     && (32'(w_start) < PANEL_PIXELS)
                     && (w_count != 16'd0)
                     && !button;

    assign w_accept = (r_state == ST_IDLE) && w_beat && w_hdr_good;

    // The timer's top bit acts as the saturation flag: set after 2^TIMEOUT_LOG2 idle cycles.
    assign w_pattern = (r_state == ST_IDLE) && (r_timer[TIMEOUT_LOG2] || button);

    assign w_addr_next = (32'(r_addr) == PANEL_PIXELS - 1) ? '0 : r_addr + 1'b1;
    assign w_pat_addr  = ADDR_W'(32'(r_cnt[ADDR_W-1:0]) % PANEL_PIXELS);
    assign w_onehot    = NUM_PANELS'(1) << r_panel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_panel          <= '0;
            r_addr           <= '0;
            r_remaining      <= '0;
            r_timer          <= '0;
            r_cnt            <= '0;
            udp_source_ready <= 1'b0;
            ctrl_en          <= '0;
            ctrl_addr        <= '0;
            ctrl_wdat        <= '0;
            led_reg          <= 1'b0;
        end else begin
            udp_source_ready <= 1'b1;
            r_cnt            <= r_cnt + 1'b1;
            ctrl_en          <= '0;

            if (w_accept) begin
                r_timer <= '0;
            end else if (!r_timer[TIMEOUT_LOG2]) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_beat) begin
                        if (w_hdr_good) begin
                            led_reg     <= ~led_reg;
                            r_addr      <= w_start;
                            r_remaining <= w_count;
                            r_panel     <= c_PANEL_W'(udp_source_dst_port[7:0]);
                            r_state     <= udp_source_last ? ST_IDLE : ST_PIXELS;
                        end else begin
                            r_state     <= udp_source_last ? ST_IDLE : ST_DROP;
                        end
                    end else if (w_pattern) begin
                        ctrl_en   <= '1;
                        ctrl_addr <= w_pat_addr;
                        ctrl_wdat <= r_cnt[TOGGLE_BIT] ? 24'h0000FF : 24'h00FF00;
                        led_reg   <= r_cnt[TOGGLE_BIT];
                    end
                end
                ST_PIXELS: begin
                    if (w_beat) begin
                        if (udp_source_error != 4'd0) begin
                            r_state <= udp_source_last ? ST_IDLE : ST_DROP;
                        end else begin
                            ctrl_en     <= w_onehot;
                            ctrl_addr   <= r_addr;
                            ctrl_wdat   <= udp_source_data[23:0];
                            r_addr      <= w_addr_next;
                            r_remaining <= r_remaining - 1'b1;
                            if (udp_source_last) begin
                                r_state <= ST_IDLE;
                            end else if (r_remaining == 16'd1) begin
                                r_state <= ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (w_beat && udp_source_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_panel_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_panel_stream_writer
// Brief    : Directed vector bench for udp_panel_stream_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_panel_stream_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        button = 1'b0;
    logic        udp_source_valid = 1'b0;
    logic        udp_source_last = 1'b0;
    logic [15:0] udp_source_dst_port = 16'h0;
    logic [3:0]  udp_source_error = 4'h0;
    logic [31:0] udp_source_data = 32'h0;
    logic        udp_source_ready;
    logic [5:0]  ctrl_en;
    logic [3:0]  ctrl_wr;
    logic [12:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic        led_reg;

    udp_panel_stream_writer #(
        .PORT_MSB     (16'h66),
        .NUM_PANELS   (6),
        .ADDR_W       (13),
        .PANEL_PIXELS (8192),
        .TIMEOUT_LOG2 (8),
        .TOGGLE_BIT   (4)
    ) u_dut (
        .clock               (clock),
        .reset               (reset),
        .button              (button),
        .udp_source_valid    (udp_source_valid),
        .udp_source_last     (udp_source_last),
        .udp_source_ready    (udp_source_ready),
        .udp_source_dst_port (udp_source_dst_port),
        .udp_source_error    (udp_source_error),
        .udp_source_data     (udp_source_data),
        .ctrl_en             (ctrl_en),
        .ctrl_wr             (ctrl_wr),
        .ctrl_addr           (ctrl_addr),
        .ctrl_wdat           (ctrl_wdat),
        .led_reg             (led_reg)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic        l;
        logic [15:0] port;
        logic [3:0]  err;
        logic [31:0] data;
        logic [5:0]  en;
        logic [12:0] addr;
        logic [23:0] wdat;
        logic        led;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic l, input logic [15:0] p, input logic [3:0] e,
                       input logic [31:0] d, input logic [5:0] en_x, input logic [12:0] a_x,
                       input logic [23:0] w_x, input logic led_x);
        vec_t r;
        r.v = v; r.l = l; r.port = p; r.err = e; r.data = d;
        r.en = en_x; r.addr = a_x; r.wdat = w_x; r.led = led_x;
        tbl.push_back(r);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic l, input logic [15:0] p,
                         input logic [3:0] e, input logic [31:0] d);
        udp_source_valid    = v;
        udp_source_last     = l;
        udp_source_dst_port = p;
        udp_source_error    = e;
        udp_source_data     = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic btn);
        @(negedge clock);
        reset  = 1'b0;
        button = btn;
        udp_source_valid = 1'b0;
        udp_source_last  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] c;
        logic        exp_led;

        // Packet-level vectors; expected outputs are those seen after the beat's edge.
        add(0,0,16'h0000,0,32'h0000_0000, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6602,0,32'h0003_0064, 6'b000000,   0,24'h000000,1);
        add(1,0,16'h6602,0,32'h0011_2233, 6'b000100, 100,24'h112233,1);
        add(1,0,16'h6602,0,32'h0044_5566, 6'b000100, 101,24'h445566,1);
        add(1,1,16'h6602,0,32'h0077_8899, 6'b000100, 102,24'h778899,1);
        add(0,0,16'h6602,0,32'h0000_0000, 6'b000000,   0,24'h000000,1);
        add(1,0,16'h6600,0,32'h0004_1FFE, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6600,0,32'h00A0_A0A1, 6'b000001,8190,24'hA0A0A1,0);
        add(1,0,16'h6600,0,32'h00A0_A0A2, 6'b000001,8191,24'hA0A0A2,0);
        add(1,0,16'h6600,0,32'h00A0_A0A3, 6'b000001,   0,24'hA0A0A3,0);
        add(1,1,16'h6600,0,32'h00A0_A0A4, 6'b000001,   1,24'hA0A0A4,0);
        add(1,0,16'h6706,0,32'h0001_0000, 6'b000000,   0,24'h000000,0);
        add(1,1,16'h6706,0,32'h00FF_FFFF, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6606,0,32'h0001_0000, 6'b000000,   0,24'h000000,0);
        add(1,1,16'h6606,0,32'h00FF_FFFF, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6601,1,32'h0001_0000, 6'b000000,   0,24'h000000,0);
        add(1,1,16'h6601,0,32'h00FF_FFFF, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6600,0,32'h0000_0000, 6'b000000,   0,24'h000000,0);
        add(1,1,16'h6600,0,32'h00FF_FFFF, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6605,0,32'h0001_0005, 6'b000000,   0,24'h000000,1);
        add(1,1,16'h6605,0,32'h00C0_FFEE, 6'b100000,   5,24'hC0FFEE,1);
        add(1,0,16'h6603,0,32'h0002_0010, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6603,0,32'h0000_0001, 6'b001000,  16,24'h000001,0);
        add(0,0,16'h6603,0,32'h0000_0000, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6603,0,32'h0000_0002, 6'b001000,  17,24'h000002,0);
        add(1,0,16'h6603,0,32'h0000_0003, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6603,0,32'h0000_0004, 6'b000000,   0,24'h000000,0);
        add(1,1,16'h6603,0,32'h0000_0005, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6603,0,32'h0005_0020, 6'b000000,   0,24'h000000,1);
        add(1,0,16'h6603,0,32'h0000_0011, 6'b001000,  32,24'h000011,1);
        add(1,1,16'h6603,0,32'h0000_0012, 6'b001000,  33,24'h000012,1);
        add(1,1,16'h6600,0,32'h0001_0000, 6'b000000,   0,24'h000000,0);
        add(1,0,16'h6604,0,32'h0003_0040, 6'b000000,   0,24'h000000,1);
        add(1,0,16'h6604,0,32'h0000_0021, 6'b010000,  64,24'h000021,1);
        add(1,0,16'h6604,2,32'h0000_0022, 6'b000000,   0,24'h000000,1);
        add(1,1,16'h6604,0,32'h0000_0023, 6'b000000,   0,24'h000000,1);
        add(1,1,16'h6600,0,32'h0001_0000, 6'b000000,   0,24'h000000,0);

        // Reset state
        @(negedge clock);
        #1;
        check("reset en",    32'(ctrl_en),          32'h0);
        check("reset addr",  32'(ctrl_addr),        32'h0);
        check("reset wdat",  32'(ctrl_wdat),        32'h0);
        check("reset led",   32'(led_reg),          32'h0);
        check("reset ready", 32'(udp_source_ready), 32'h0);
        do_reset(1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].l, tbl[i].port, tbl[i].err, tbl[i].data);
            check($sformatf("vec%0d en", i), 32'(ctrl_en), 32'(tbl[i].en));
            if (tbl[i].en != 6'd0) begin
                check($sformatf("vec%0d addr", i), 32'(ctrl_addr), 32'(tbl[i].addr));
                check($sformatf("vec%0d wdat", i), 32'(ctrl_wdat), 32'(tbl[i].wdat));
            end
            check($sformatf("vec%0d led", i), 32'(led_reg), 32'(tbl[i].led));
        end
        check("ready", 32'(udp_source_ready), 32'h1);
        check("wr",    32'(ctrl_wr),          32'h7);

        // Idle timeout: fill starts on the 257th edge after release.
        do_reset(1'b0);
        for (int k = 1; k <= 300; k++) begin
            drive(0, 0, 16'h0, 0, 32'h0);
            c = 32'(k - 1);
            if (k == 256) begin
                check("timeout early en", 32'(ctrl_en), 32'h0);
            end else if (k >= 257) begin
                check($sformatf("fill%0d en", k),   32'(ctrl_en),   32'h3F);
                check($sformatf("fill%0d addr", k), 32'(ctrl_addr), c & 32'h1FFF);
                check($sformatf("fill%0d wdat", k), 32'(ctrl_wdat), c[4] ? 32'h0000FF : 32'h00FF00);
                check($sformatf("fill%0d led", k),  32'(led_reg),   32'(c[4]));
            end
        end
        c = 32'd299;
        exp_led = ~c[4];
        drive(1, 0, 16'h6602, 0, 32'h0001_0003);
        check("cancel hdr en",  32'(ctrl_en), 32'h0);
        check("cancel hdr led", 32'(led_reg), 32'(exp_led));
        drive(1, 1, 16'h6602, 0, 32'h00AB_CDEF);
        check("cancel pix en",   32'(ctrl_en),   32'h04);
        check("cancel pix addr", 32'(ctrl_addr), 32'd3);
        check("cancel pix wdat", 32'(ctrl_wdat), 32'hABCDEF);
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 16'h0, 0, 32'h0);
            check($sformatf("restart%0d en", k), 32'(ctrl_en), 32'h0);
        end

        // Button held: immediate fill, packet drained without panel writes.
        do_reset(1'b1);
        drive(0, 0, 16'h0, 0, 32'h0);
        check("btn fill en",   32'(ctrl_en),   32'h3F);
        check("btn fill addr", 32'(ctrl_addr), 32'h0);
        check("btn fill wdat", 32'(ctrl_wdat), 32'h00FF00);
        drive(1, 0, 16'h6601, 0, 32'h0002_0000);
        check("btn hdr en", 32'(ctrl_en), 32'h0);
        drive(1, 0, 16'h6601, 0, 32'h0000_1111);
        check("btn drain0 en", 32'(ctrl_en), 32'h0);
        drive(1, 1, 16'h6601, 0, 32'h0000_2222);
        check("btn drain1 en", 32'(ctrl_en), 32'h0);
        drive(0, 0, 16'h0, 0, 32'h0);
        check("btn refill en", 32'(ctrl_en), 32'h3F);
        button = 1'b0;

        // Asynchronous reset in the middle of a packet.
        do_reset(1'b0);
        drive(0, 0, 16'h0, 0, 32'h0);
        drive(1, 0, 16'h6602, 0, 32'h0005_0000);
        drive(1, 0, 16'h6602, 0, 32'h0012_3456);
        check("pre-rst en",  32'(ctrl_en), 32'h04);
        check("pre-rst led", 32'(led_reg), 32'h1);
        reset = 1'b0;
        #1;
        check("async en",    32'(ctrl_en),          32'h0);
        check("async addr",  32'(ctrl_addr),        32'h0);
        check("async wdat",  32'(ctrl_wdat),        32'h0);
        check("async led",   32'(led_reg),          32'h0);
        check("async ready", 32'(udp_source_ready), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        drive(0, 0, 16'h0, 0, 32'h0);
        drive(1, 0, 16'h6602, 0, 32'h0000_3456);
        check("post-rst drop0 en", 32'(ctrl_en), 32'h0);
        drive(1, 1, 16'h6602, 0, 32'h0000_789A);
        check("post-rst drop1 en", 32'(ctrl_en), 32'h0);
        drive(1, 0, 16'h6600, 0, 32'h0001_0009);
        drive(1, 1, 16'h6600, 0, 32'h0055_AA55);
        check("recover en",   32'(ctrl_en),   32'h01);
        check("recover addr", 32'(ctrl_addr), 32'd9);
        check("recover wdat", 32'(ctrl_wdat), 32'h55AA55);
        drive(0, 0, 16'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
